key_tracker: RTL and testbench
==============================

Name: key_tracker

Overview:
- Sequential game-logic block that produces `key_find` and `isDark`, which the sprite overlay renderer consumes.
- Watches the top-level `state`, the player position in 320x240 half-resolution coordinates, and a one-pulse interact button.
- Advances key pickup progress, toggles and times out the STAGE2 light, and emits pickup and stage-clear pulses to the top-level FSM.

Parameters:
- PLAYER_W, 16, player hit-box width and height in half-res pixels.
- LIGHT_TICKS, 300, tick pulses the light stays on after the switch is used (5 s at a 60 Hz tick).
- SW_GUARD, 15, tick pulses during which interact is ignored after a switch toggle.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- state  in  4  top-level game state (TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8)
- player_x  in  9  player hit-box left edge, half-res
- player_y  in  9  player hit-box top edge, half-res
- interact  in  1  one-cycle debounced button pulse
- tick  in  1  one-cycle timebase strobe
- key_find  out  2  0/1/2 = hunting key1/key2/key3; 3 = all keys found
- isDark  out  1  room light off (meaningful in STAGE2 only)
- key_get  out  1  one-cycle pulse on each successful pickup
- stage_clear  out  1  one-cycle pulse when key_find becomes 3

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on `rst`.
- Reset values:
  - key_find=0, isDark=0, key_get=0, stage_clear=0.
  - FSM=IDLE, light_cnt=0, guard_cnt=0, prev_state=TITLE.
- Object boxes, inclusive-low / exclusive-high, each 10x10:
  - KEY1 (70,40), KEY2 (235,40), KEY3 (215,220), SWITCH (70,220).
- Hit test: hit(o) = player_x < ox+10 and player_x+PLAYER_W > ox and player_y < oy+10 and player_y+PLAYER_W > oy.
  - Compute sums at 10 bits; no wrap.
- Stage entry: when state != prev_state and the new state is STAGE1, STAGE2 or STAGE3:
  - key_find <= 0, light_cnt <= 0, guard_cnt <= 0, FSM <= HUNT.
  - isDark <= 1 if STAGE2, else 0.
  - Entry has priority over every other event in that cycle.
- Leaving to any non-stage state: FSM <= IDLE. key_find and isDark hold their value so the SUCCESS/FAIL screens see final values.
- FSM states:
  - IDLE: ignore interact and tick. Outputs hold; pulses are 0.
  - HUNT: on interact with hit(target), where target = KEY1/KEY2/KEY3 for key_find 0/1/2:
    - key_find <= key_find+1 and key_get=1 for the next cycle.
    - If key_find was 2, also stage_clear=1 for the next cycle and FSM <= DONE.
  - HUNT, KEY1 in STAGE2: picking KEY1 requires isDark=0 (the key is hidden in the dark).
  - DONE: key_find=3 held; interact ignored except for the switch rules below. Exit only via stage entry or leaving to a non-stage state.
- Switch (STAGE2, FSM in HUNT or DONE):
  - interact with hit(SWITCH) and guard_cnt=0 toggles isDark.
  - On the toggle, guard_cnt <= SW_GUARD.
  - If the light turns on, light_cnt <= LIGHT_TICKS.
  - If the light turns off, light_cnt <= 0.
- Timers:
  - On tick, guard_cnt decrements if nonzero.
  - On tick, if isDark=0 and light_cnt != 0: light_cnt decrements; on the 1->0 transition, isDark <= 1.
  - Timers never underflow.
- Simultaneous interact:
  - Key and switch boxes are disjoint for PLAYER_W<=16; the key rule is still evaluated first.
  - In one cycle, either a pickup or a toggle happens, never both.
- Simultaneous tick and expiry with a switch toggle: the toggle wins (light on, reload LIGHT_TICKS).
- Switch in STAGE1/STAGE3: ignored; isDark stays 0.
- Output timing: all outputs registered; a pickup is visible 1 cycle after the interact pulse.
- rst asserted mid-stage: returns to reset values next edge. A stage is re-entered only when state changes after rst is released; if state is already STAGE_n, entry fires on the first cycle because prev_state=TITLE.

Decomposition:
- Shared package game_pkg:
  - state encodings TITLE..FAIL.
  - Object box origins KEY1/KEY2/KEY3/SWITCH and OBJ_SIZE=10.
  - These are also used by the sprite overlay renderer.
- One sub-module: box_hit (combinational overlap test, parameterised by origin), instantiated four times.

Test Plan:
- rst, state=STAGE1, player (66,36), interact -> key_find=1, key_get pulse 1 cycle; interact repeated at same spot -> no change.
- STAGE1, sequential pickups at (66,36), (231,36), (211,216) -> key_find 1, 2, 3; stage_clear pulses once on the third; extra interact -> key_find stays 3.
- Entering STAGE2 -> isDark=1. Interact at KEY1 -> key_find stays 0. Interact at (66,216) -> isDark=0. Then KEY1 interact -> key_find=1.
- STAGE2 with light on and LIGHT_TICKS=3: 3 tick pulses -> isDark=1 after the third. A second switch interact within SW_GUARD ticks -> ignored.
- Mid-STAGE3 with key_find=2, state->FAIL then state->STAGE1 -> key_find held at 2 during FAIL, reset to 0 on STAGE1 entry. Assert rst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: top-level state encodings, object boxes and tracker FSM states.
package game_pkg;

  typedef enum logic [3:0] {
    Title    = 4'd0,
    Staff    = 4'd1,
    Stage1   = 4'd2,
    Success1 = 4'd3,
    Stage2   = 4'd4,
    Success2 = 4'd5,
    Stage3   = 4'd6,
    Success3 = 4'd7,
    Fail     = 4'd8
  } game_state_e;

  // Object boxes in half-res pixels, origin is the top-left corner.
  localparam int unsigned ObjSize = 10;
  localparam int unsigned Key1X   = 70;
  localparam int unsigned Key1Y   = 40;
  localparam int unsigned Key2X   = 235;
  localparam int unsigned Key2Y   = 40;
  localparam int unsigned Key3X   = 215;
  localparam int unsigned Key3Y   = 220;
  localparam int unsigned SwitchX = 70;
  localparam int unsigned SwitchY = 220;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHunt = 2'd1,
    StDone = 2'd2
  } tracker_fsm_e;

  function automatic logic is_stage(logic [3:0] s);
    return (s == Stage1) || (s == Stage2) || (s == Stage3);
  endfunction

endpackage

// File: rtl/key_tracker_if.sv
// Signal bundle between the top-level game FSM / input logic and the key tracker.
interface key_tracker_if;
  logic [3:0] state;
  logic [8:0] player_x;
  logic [8:0] player_y;
  logic       interact;
  logic       tick;
  logic [1:0] key_find;
  logic       isDark;
  logic       key_get;
  logic       stage_clear;

  modport master (
    output state, player_x, player_y, interact, tick,
    input  key_find, isDark, key_get, stage_clear
  );

  modport slave (
    input  state, player_x, player_y, interact, tick,
    output key_find, isDark, key_get, stage_clear
  );
endinterface

// File: rtl/box_hit.sv
// Combinational overlap test between the player hit-box and one fixed object box.
module box_hit
  import game_pkg::*;
#(
  parameter int unsigned OriginX = 0,
  parameter int unsigned OriginY = 0,
  parameter int unsigned PlayerW = 16
) (
  input  logic [8:0] player_x_i,
  input  logic [8:0] player_y_i,
  output logic       hit_o
);

  // Widened to 10 bits so x + PlayerW never wraps.
  logic [9:0] px;
  logic [9:0] py;

  assign px = {1'b0, player_x_i};
  assign py = {1'b0, player_y_i};

  // Inclusive-low / exclusive-high overlap on both axes.
  assign hit_o = (px < 10'(OriginX + ObjSize)) &&
                 ((px + 10'(PlayerW)) > 10'(OriginX)) &&
                 (py < 10'(OriginY + ObjSize)) &&
                 ((py + 10'(PlayerW)) > 10'(OriginY));

endmodule

// File: rtl/key_tracker.sv
// Key pickup progress, STAGE2 light switch with timeout, and pickup/clear pulses.
module key_tracker
  import game_pkg::*;
#(
  parameter int unsigned PLAYER_W    = 16,
  parameter int unsigned LIGHT_TICKS = 300,
  parameter int unsigned SW_GUARD    = 15
) (
  input  logic         clk,
  input  logic         rst,
  key_tracker_if.slave bus
);

  localparam int unsigned LightW = (LIGHT_TICKS > 0) ? $clog2(LIGHT_TICKS + 1) : 1;
  localparam int unsigned GuardW = (SW_GUARD > 0) ? $clog2(SW_GUARD + 1) : 1;

  tracker_fsm_e      fsm_q, fsm_d;
  logic [3:0]        prev_state_q;
  logic [1:0]        key_find_q, key_find_d;
  logic              is_dark_q, is_dark_d;
  logic              key_get_q, key_get_d;
  logic              stage_clear_q, stage_clear_d;
  logic [LightW-1:0] light_q, light_d;
  logic [GuardW-1:0] guard_q, guard_d;

  logic hit_key1, hit_key2, hit_key3, hit_switch;
  logic target_hit, stage_entry, in_stage, active;
  logic key_blocked, pickup, toggle, tick_en;

  box_hit #(.OriginX(Key1X), .OriginY(Key1Y), .PlayerW(PLAYER_W)) u_hit_key1 (
    .player_x_i(bus.player_x), .player_y_i(bus.player_y), .hit_o(hit_key1)
  );
  box_hit #(.OriginX(Key2X), .OriginY(Key2Y), .PlayerW(PLAYER_W)) u_hit_key2 (
    .player_x_i(bus.player_x), .player_y_i(bus.player_y), .hit_o(hit_key2)
  );
  box_hit #(.OriginX(Key3X), .OriginY(Key3Y), .PlayerW(PLAYER_W)) u_hit_key3 (
    .player_x_i(bus.player_x), .player_y_i(bus.player_y), .hit_o(hit_key3)
  );
  box_hit #(.OriginX(SwitchX), .OriginY(SwitchY), .PlayerW(PLAYER_W)) u_hit_switch (
    .player_x_i(bus.player_x), .player_y_i(bus.player_y), .hit_o(hit_switch)
  );

  // Event decode: which key is the current target, and whether a pickup or toggle fires.
  always_comb begin
    case (key_find_q)
      2'd0:    target_hit = hit_key1;
      2'd1:    target_hit = hit_key2;
      2'd2:    target_hit = hit_key3;
      default: target_hit = 1'b0;
    endcase
    stage_entry = (bus.state != prev_state_q) && is_stage(bus.state);
    in_stage    = is_stage(bus.state);
    active      = in_stage && (fsm_q != StIdle) && !stage_entry;
    // KEY1 in STAGE2 sits in the dark room and cannot be found until the light is on.
    key_blocked = (bus.state == Stage2) && (key_find_q == 2'd0) && is_dark_q;
    pickup      = active && (fsm_q == StHunt) && bus.interact && target_hit && !key_blocked;
    toggle      = active && (bus.state == Stage2) && bus.interact && hit_switch &&
                  (guard_q == '0) && !pickup;
    tick_en     = active && bus.tick;
  end

  // FSM next state: entry beats everything, leaving a stage parks in idle.
  always_comb begin
    fsm_d = fsm_q;
    if (stage_entry) begin
      fsm_d = StHunt;
    end else if (!in_stage) begin
      fsm_d = StIdle;
    end else if (pickup && (key_find_q == 2'd2)) begin
      fsm_d = StDone;
    end
  end

  // Output/datapath next values; the toggle is applied after the timers so it wins.
  always_comb begin
    key_find_d    = key_find_q;
    is_dark_d     = is_dark_q;
    light_d       = light_q;
    guard_d       = guard_q;
    key_get_d     = 1'b0;
    stage_clear_d = 1'b0;
    if (stage_entry) begin
      key_find_d = 2'd0;
      light_d    = '0;
      guard_d    = '0;
      is_dark_d  = (bus.state == Stage2);
    end else begin
      if (tick_en) begin
        if (guard_q != '0) guard_d = guard_q - GuardW'(1);
        if (!is_dark_q && (light_q != '0)) begin
          light_d = light_q - LightW'(1);
          if (light_q == LightW'(1)) is_dark_d = 1'b1;
        end
      end
      if (pickup) begin
        key_find_d = key_find_q + 2'd1;
        key_get_d  = 1'b1;
        if (key_find_q == 2'd2) stage_clear_d = 1'b1;
      end
      if (toggle) begin
        is_dark_d = !is_dark_q;
        guard_d   = GuardW'(SW_GUARD);
        light_d   = is_dark_q ? LightW'(LIGHT_TICKS) : '0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= StIdle;
      prev_state_q  <= Title;
      key_find_q    <= 2'd0;
      is_dark_q     <= 1'b0;
      key_get_q     <= 1'b0;
      stage_clear_q <= 1'b0;
      light_q       <= '0;
      guard_q       <= '0;
    end else begin
      fsm_q         <= fsm_d;
      prev_state_q  <= bus.state;
      key_find_q    <= key_find_d;
      is_dark_q     <= is_dark_d;
      key_get_q     <= key_get_d;
      stage_clear_q <= stage_clear_d;
      light_q       <= light_d;
      guard_q       <= guard_d;
    end
  end

  assign bus.key_find    = key_find_q;
  assign bus.isDark      = is_dark_q;
  assign bus.key_get     = key_get_q;
  assign bus.stage_clear = stage_clear_q;

endmodule

// File: tb/tb_key_tracker.sv
// Bench for key_tracker: directed vector table, hand sequences, then random vs. a rule model.
module tb_key_tracker;

  localparam int PW = 16;
  localparam int LT = 3;
  localparam int SG = 5;

  localparam logic [3:0] STITLE = 4'd0, S1 = 4'd2, SU1 = 4'd3, S2 = 4'd4, S3 = 4'd6,
                         SFAIL = 4'd8;

  typedef struct {
    logic       r;
    logic [3:0] st;
    int         px;
    int         py;
    logic       it;
    logic       tk;
    logic [1:0] ek;
    logic       ed;
    logic       eg;
    logic       ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  key_tracker_if bus ();

  key_tracker #(.PLAYER_W(PW), .LIGHT_TICKS(LT), .SW_GUARD(SG)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs[$];

  // Reference model state (plain integers, rules applied directly).
  int  m_key, m_light, m_guard, m_prev;
  bit  m_dark, m_get, m_clr, m_active;

  function automatic bit hit(int px, int py, int ox, int oy);
    return (px < ox + 10) && (px + PW > ox) && (py < oy + 10) && (py + PW > oy);
  endfunction

  function automatic bit stage(int s);
    return s == 2 || s == 4 || s == 6;
  endfunction

  task automatic model_step(bit r, int st, int px, int py, bit it, bit tk);
    int kx[3] = '{70, 235, 215};
    int ky[3] = '{40, 40, 220};
    bit od, picked;
    int og;
    m_get = 0;
    m_clr = 0;
    if (r) begin
      m_key = 0; m_dark = 0; m_light = 0; m_guard = 0; m_prev = 0; m_active = 0;
      return;
    end
    od = m_dark;
    og = m_guard;
    picked = 0;
    if (st != m_prev && stage(st)) begin
      m_key = 0; m_light = 0; m_guard = 0; m_active = 1; m_dark = (st == 4);
    end else if (!stage(st)) begin
      m_active = 0;
    end else if (m_active) begin
      if (tk) begin
        if (m_guard > 0) m_guard--;
        if (!od && m_light > 0) begin
          m_light--;
          if (m_light == 0) m_dark = 1;
        end
      end
      if (it && m_key < 3 && hit(px, py, kx[m_key], ky[m_key]) &&
          !(st == 4 && m_key == 0 && od)) begin
        picked = 1;
        m_key++;
        m_get = 1;
        m_clr = (m_key == 3);
      end
      if (st == 4 && it && !picked && og == 0 && hit(px, py, 70, 220)) begin
        m_dark = !od;
        m_guard = SG;
        m_light = od ? LT : 0;
      end
    end
    m_prev = st;
  endtask

  task automatic apply(logic r, logic [3:0] st, int px, int py, logic it, logic tk);
    rst = r;
    bus.state = st;
    bus.player_x = 9'(px);
    bus.player_y = 9'(py);
    bus.interact = it;
    bus.tick = tk;
    @(posedge clk);
    #1;
    bus.interact = 1'b0;
    bus.tick = 1'b0;
  endtask

  task automatic check(string name, logic [4:0] got, logic [4:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got key/dark/get/clr=%b required %b", name, got, exp);
  endtask

  function automatic logic [4:0] outs();
    return {bus.key_find, bus.isDark, bus.key_get, bus.stage_clear};
  endfunction

  task automatic add(logic r, logic [3:0] st, int px, int py, logic it, logic tk,
                     logic [1:0] ek, logic ed, logic eg, logic ec);
    vecs.push_back('{r, st, px, py, it, tk, ek, ed, eg, ec});
  endtask

  task automatic step_chk(string name, logic r, logic [3:0] st, int px, int py, logic it,
                          logic [1:0] ek, logic ed, logic eg, logic ec);
    apply(r, st, px, py, it, 1'b0);
    check(name, outs(), {ek, ed, eg, ec});
  endtask

  initial begin
    rst = 1'b1;
    bus.state = STITLE;
    bus.player_x = '0;
    bus.player_y = '0;
    bus.interact = 1'b0;
    bus.tick = 1'b0;

    //   rst st  px   py   it tk  key dark get clr
    add(1, S1, 0,   0,   0, 0,  0,  0,   0,  0);   // reset state
    add(0, S1, 0,   0,   0, 0,  0,  0,   0,  0);   // stage1 entry
    add(0, S1, 66,  36,  1, 0,  1,  0,   1,  0);   // key1
    add(0, S1, 66,  36,  0, 0,  1,  0,   0,  0);   // pulse is one cycle
    add(0, S1, 66,  36,  1, 0,  1,  0,   0,  0);   // same spot again: no change
    add(0, S1, 231, 36,  1, 0,  2,  0,   1,  0);   // key2
    add(0, S1, 211, 216, 1, 0,  3,  0,   1,  1);   // key3 + clear
    add(0, S1, 211, 216, 1, 0,  3,  0,   0,  0);   // extra interact
    add(0, S1, 66,  36,  1, 0,  3,  0,   0,  0);
    add(0, S2, 0,   0,   0, 0,  0,  1,   0,  0);   // stage2 entry: dark
    add(0, S2, 66,  36,  1, 0,  0,  1,   0,  0);   // key1 hidden in dark
    add(0, S2, 66,  216, 1, 0,  0,  0,   0,  0);   // switch: light on
    add(0, S2, 66,  36,  1, 0,  1,  0,   1,  0);   // key1 now visible
    add(0, S2, 0,   0,   0, 1,  1,  0,   0,  0);   // tick 1
    add(0, S2, 0,   0,   0, 1,  1,  0,   0,  0);   // tick 2
    add(0, S2, 0,   0,   0, 1,  1,  1,   0,  0);   // tick 3: light expires
    add(0, S2, 66,  216, 1, 0,  1,  1,   0,  0);   // within guard: ignored
    add(0, S2, 0,   0,   0, 1,  1,  1,   0,  0);
    add(0, S2, 66,  216, 1, 1,  1,  1,   0,  0);   // guard was 1: still ignored
    add(0, S2, 66,  216, 1, 0,  1,  0,   0,  0);   // guard clear: toggles on
    add(0, S2, 66,  216, 1, 0,  1,  0,   0,  0);   // guard reloaded: ignored
    add(0, S3, 0,   0,   0, 0,  0,  0,   0,  0);   // stage3 entry
    add(0, S3, 66,  216, 1, 0,  0,  0,   0,  0);   // switch ignored in stage3
    add(0, S3, 66,  36,  1, 0,  1,  0,   1,  0);

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].st, vecs[i].px, vecs[i].py, vecs[i].it, vecs[i].tk);
      check($sformatf("vec%0d", i), outs(), {vecs[i].ek, vecs[i].ed, vecs[i].eg, vecs[i].ec});
    end

    // Leave stage with key_find=2, hold through FAIL, reset on re-entry.
    step_chk("s3_key2",      0, S3,    231, 36,  1, 2, 0, 1, 0);
    step_chk("fail_hold",    0, SFAIL, 0,   0,   0, 2, 0, 0, 0);
    step_chk("fail_ignore",  0, SFAIL, 211, 216, 1, 2, 0, 0, 0);
    step_chk("s1_reentry",   0, S1,    0,   0,   0, 0, 0, 0, 0);
    step_chk("s1_key1",      0, S1,    66,  36,  1, 1, 0, 1, 0);
    step_chk("rst_mid",      1, S1,    66,  36,  0, 0, 0, 0, 0);
    // State already STAGE2 when rst releases: entry fires immediately.
    step_chk("rst_s2",       1, S2,    0,   0,   0, 0, 0, 0, 0);
    step_chk("s2_first",     0, S2,    0,   0,   0, 0, 1, 0, 0);
    // Success screen keeps the dark flag.
    step_chk("success_hold", 0, SU1,   66,  216, 1, 0, 1, 0, 0);

    // Randomized run against the rule model.
    begin
      logic [3:0] sts[6] = '{S1, S2, S3, SU1, SFAIL, STITLE};
      int ox[4] = '{70, 235, 215, 70};
      int oy[4] = '{40, 40, 220, 220};
      logic [3:0] st = S2;
      model_step(1, st, 0, 0, 0, 0);
      apply(1'b1, st, 0, 0, 1'b0, 1'b0);
      for (int n = 0; n < 3000; n++) begin
        int o, px, py;
        bit r, it, tk;
        if ($urandom_range(0, 39) == 0) st = sts[$urandom_range(0, 5)];
        if ($urandom_range(0, 2) != 0 && stage(int'(st)) == 0) st = sts[$urandom_range(0, 2)];
        o = $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 0) o = 3;
        px = ox[o] + $urandom_range(0, 30) - 18;
        py = oy[o] + $urandom_range(0, 30) - 18;
        r = ($urandom_range(0, 499) == 0);
        it = ($urandom_range(0, 2) == 0);
        tk = ($urandom_range(0, 1) == 0);
        model_step(r, int'(st), px, py, it, tk);
        apply(r, st, px, py, it, tk);
        check($sformatf("rand%0d", n), outs(),
              {2'(m_key), m_dark, m_get, m_clr});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
